mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle datapath.
- Consumes the A/B register outputs (rs/rt operands) on a start pulse from the control FSM.
- Produces the 64-bit result that the HI and LO registers load when `done` is asserted.
- Used for MIPS MULT and DIV; frees the ALU for other work during the iteration.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request from control; sampled only in IDLE.
- op  input  1  0 = MULT, 1 = DIV; sampled with start.
- a_in  input  WIDTH  operand rs (A register output), two's complement.
- b_in  input  WIDTH  operand rt (B register output), two's complement.
- hi_out  output  WIDTH  MULT: product[2*WIDTH-1:WIDTH]; DIV: remainder.
- lo_out  output  WIDTH  MULT: product[WIDTH-1:0]; DIV: quotient.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi_out/lo_out are valid and HI/LO registers should load.
- div_by_zero  output  1  one-cycle pulse together with done when DIV has b_in == 0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset: when reset == 0 at an edge, the unit goes to IDLE and sets hi_out = 0, lo_out = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
  - This applies in any state; an operation in progress is discarded and no done is issued.
- States: IDLE, RUN, FINISH.
- IDLE, start = 1 at edge E:
  - Latch op, a_in, b_in.
  - Record the operand signs; load magnitudes (DIV) or operands (MULT).
  - Set counter = WIDTH, busy = 1, and go to RUN.
  - Exception: DIV with b_in == 0 goes straight to FINISH with the zero flag set.
- RUN:
  - MULT: one radix-2 Booth step per cycle (add/sub multiplicand, then arithmetic shift right of the 2*WIDTH+1 accumulator).
  - DIV: one restoring-division step per cycle on magnitudes (shift the remainder left, trial subtract, quotient bit = no-borrow).
  - Counter decrements each cycle; after WIDTH steps, go to FINISH.
- FINISH (one cycle), then return to IDLE:
  - MULT: hi_out/lo_out take the accumulator result.
  - DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend. lo_out = quotient, hi_out = remainder.
  - Divide by zero: hi_out/lo_out keep their previous values and div_by_zero = 1.
  - done = 1; busy stays 1 through the FINISH cycle.
- Latency:
  - Normal case: done is high in the cycle after edge E + WIDTH + 1 (33 edges for WIDTH = 32).
  - Divide by zero: done is high in the cycle after edge E + 1.
- Outputs hold: hi_out/lo_out keep their last result until the next FINISH; done and div_by_zero are 0 outside FINISH.
- start while busy (RUN or FINISH) is ignored; no queuing. start in the same cycle that done is high is also ignored.
- Operand stability: a_in/b_in/op are only sampled at edge E; later changes have no effect.
- Arithmetic rules:
  - MULT is a full signed 64-bit product.
  - DIV of INT_MIN by -1 wraps: lo_out = 0x80000000, hi_out = 0.
  - DIV truncates toward zero, and the identity a = q*b + r holds.
- No unsigned variants (MULTU/DIVU) are in scope.

Test Plan:
- Reset low for 2 cycles, then high → hi_out = lo_out = 0, busy = 0, done = 0.
- MULT a = 7, b = -3 (0xFFFFFFFD) → done exactly 33 edges after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for 33 cycles.
- MULT a = b = 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- DIV a = -7, b = 2 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- DIV a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV a = 5, b = 0 after a prior result hi/lo = 0x1/0x2 → done and div_by_zero high 1 edge after start; hi/lo stay 0x1/0x2.
- Mid-operation events:
  - MULT started, start re-pulsed at cycle 10 with different operands → ignored; the original result appears at cycle 33.
  - Separately, reset driven low at cycle 15 → busy = 0 next cycle, no done, outputs = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle datapath.
// MULT uses radix-2 Booth recoding; DIV uses restoring division on operand
// magnitudes with a sign fix-up on the way out. One step per clock, WIDTH steps.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q;
  logic             op_q;          // 0 = MULT, 1 = DIV
  logic             a_neg_q;
  logic             b_neg_q;
  logic             zero_q;        // DIV with a zero divisor
  logic [WIDTH-1:0] opb_q;         // MULT: multiplicand; DIV: divisor magnitude
  logic [WIDTH:0]   hi_acc_q;      // MULT: Booth upper half (one guard bit); DIV: partial remainder
  logic [WIDTH-1:0] lo_acc_q;      // MULT: multiplier / product low; DIV: dividend / quotient
  logic             lsb_q;         // Booth q[-1]
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] hi_out_q;
  logic [WIDTH-1:0] lo_out_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   hi_acc_d;
  logic [WIDTH-1:0] lo_acc_d;
  logic             lsb_d;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // INT_MIN maps onto itself, which reads correctly as an unsigned magnitude.
  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  // One iteration step of whichever operation is in flight.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hi_acc_d  = hi_acc_q;
    lo_acc_d  = lo_acc_q;
    lsb_d     = lsb_q;
    booth_sum = hi_acc_q;
    rem_sh    = '0;
    trial     = '0;
    if (!op_q) begin
      // Guard bit keeps the add/sub exact even for a multiplicand of INT_MIN.
      case ({lo_acc_q[0], lsb_q})
        2'b01:   booth_sum = hi_acc_q + {opb_q[WIDTH-1], opb_q};
        2'b10:   booth_sum = hi_acc_q - {opb_q[WIDTH-1], opb_q};
        default: booth_sum = hi_acc_q;
      endcase
      hi_acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      lo_acc_d = {booth_sum[0], lo_acc_q[WIDTH-1:1]};
      lsb_d    = lo_acc_q[0];
    end else begin
      rem_sh   = {hi_acc_q[WIDTH-1:0], lo_acc_q[WIDTH-1]};
      trial    = {1'b0, rem_sh} - {2'b00, opb_q};
      hi_acc_d = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
      lo_acc_d = {lo_acc_q[WIDTH-2:0], ~trial[WIDTH+1]};
    end
  end

  // Control FSM with registered outputs and the iteration datapath registers.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      zero_q   <= 1'b0;
      opb_q    <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      lsb_q    <= 1'b0;
      count_q  <= '0;
      hi_out_q <= '0;
      lo_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done_q) begin
            op_q     <= op;
            a_neg_q  <= a_in[WIDTH-1];
            b_neg_q  <= b_in[WIDTH-1];
            hi_acc_q <= '0;
            lsb_q    <= 1'b0;
            count_q  <= CW'(WIDTH);
            busy_q   <= 1'b1;
            if (op) begin
              opb_q    <= b_mag;
              lo_acc_q <= a_mag;
            end else begin
              opb_q    <= a_in;
              lo_acc_q <= b_in;
            end
            if (op && (b_in == '0)) begin
              zero_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              zero_q  <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          hi_acc_q <= hi_acc_d;
          lo_acc_q <= lo_acc_d;
          lsb_q    <= lsb_d;
          count_q  <= count_q - CW'(1);
          if (count_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b1;
          dbz_q   <= zero_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!zero_q) begin
            if (op_q) begin
              lo_out_q <= (a_neg_q ^ b_neg_q) ? -lo_acc_q : lo_acc_q;
              hi_out_q <= a_neg_q ? -hi_acc_q[WIDTH-1:0] : hi_acc_q[WIDTH-1:0];
            end else begin
              lo_out_q <= lo_acc_q;
              hi_out_q <= hi_acc_q[WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_out      = hi_out_q;
  assign lo_out      = lo_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one operation and check result, latency and busy profile.
  // repulse_at >= 0 re-pulses start with other operands that many cycles after start.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int repulse_at, input bit start_in_done);
    longint      la, lb, q, r;
    logic [63:0] p;
    logic [31:0] eh, el;
    logic        ez;
    int          exp_lat, lat, busy_cyc;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (!o) begin
      p = la * lb;
      eh = p[63:32]; el = p[31:0]; ez = 1'b0; exp_lat = 33;
    end else if (b == 32'd0) begin
      eh = model_hi; el = model_lo; ez = 1'b1; exp_lat = 1;
    end else begin
      q = la / lb;
      r = la % lb;
      el = q[31:0]; eh = r[31:0]; ez = 1'b0; exp_lat = 33;
    end

    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
    lat = 0;
    busy_cyc = 0;
    while (lat < 100) begin
      if (busy) busy_cyc++;
      if (lat == repulse_at) begin
        start = 1'b1; op = ~o; a_in = $urandom; b_in = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) break;
    end
    start = 1'b0;

    check("latency",     64'(lat),         64'(exp_lat));
    check("busy_cycles", 64'(busy_cyc),    64'(exp_lat));
    check("hi_out",      64'(hi_out),      64'(eh));
    check("lo_out",      64'(lo_out),      64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    check("busy_at_done", 64'(busy),       64'(0));
    model_hi = eh;
    model_lo = el;

    if (start_in_done) begin
      start = 1'b1; op = 1'($urandom); a_in = $urandom; b_in = $urandom | 32'd1;
    end
    tick();
    start = 1'b0;
    check("done_pulse_end", 64'(done),        64'(0));
    check("dbz_pulse_end",  64'(div_by_zero), 64'(0));
    check("busy_after",     64'(busy),        64'(0));
    check("hi_hold",        64'(hi_out),      64'(eh));
    check("lo_hold",        64'(lo_out),      64'(el));
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [31:0] ra, rb;
    logic        ro;
    int          done_seen;

    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_0000;
    specials[4] = 32'h0000_0001;
    specials[5] = 32'hFFFF_FFFE;

    reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b1;
    tick();
    check("rst_hi",   64'(hi_out),      64'(0));
    check("rst_lo",   64'(lo_out),      64'(0));
    check("rst_busy_rel", 64'(busy),    64'(0));
    check("rst_done_rel", 64'(done),    64'(0));
    check("rst_dbz",  64'(div_by_zero), 64'(0));

    // Directed cases.
    do_op(1'b0, 32'd7,         32'hFFFF_FFFD, -1, 1'b0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, 1'b1);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2,         -1, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1);
    do_op(1'b1, 32'd5,         32'd2,         -1, 1'b0);
    check("prior_hi", 64'(hi_out), 64'(32'h1));
    check("prior_lo", 64'(lo_out), 64'(32'h2));
    do_op(1'b1, 32'd5,         32'd0,         -1, 1'b0);
    do_op(1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 10, 1'b0);
    do_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 10, 1'b1);

    // Reset in the middle of a MULT discards it.
    start = 1'b1; op = 1'b0; a_in = 32'd1000; b_in = 32'd2000;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("mid_busy_before", 64'(busy), 64'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_busy", 64'(busy),   64'(0));
    check("mid_rst_done", 64'(done),   64'(0));
    check("mid_rst_hi",   64'(hi_out), 64'(0));
    check("mid_rst_lo",   64'(lo_out), 64'(0));
    model_hi = '0;
    model_lo = '0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'(0));

    // Random traffic mixing arbitrary and corner operands.
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >>> $urandom_range(0, 30);
      do_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
